// File: rtl/pipe_in_verify.sv
// Pipe-in checker: compares each incoming word against a locally generated sequence.
// Mismatches reach error_count two edges after the write; first-error capture is sticky.
// Writes in RUN are always checked. pipe_in_ready is an advisory throttle; the block never stalls.
module pipe_in_verify #(
    parameter int DATA_WIDTH     = 32,
    parameter int ERR_WIDTH      = 32,
    parameter int THROTTLE_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pipe_in_write,
    input  logic [DATA_WIDTH-1:0]     pipe_in_data,
    output logic                      pipe_in_ready,
    input  logic                      throttle_set,
    input  logic [THROTTLE_WIDTH-1:0] throttle_val,
    input  logic [2:0]                pattern,
    input  logic [DATA_WIDTH-1:0]     fixed_pattern,
    output logic [ERR_WIDTH-1:0]      error_count,
    output logic [31:0]               word_count,
    output logic                      first_err_valid,
    output logic [31:0]               first_err_index
);

    localparam int LANES = DATA_WIDTH / 32;
    localparam int WB    = $clog2(DATA_WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    logic [1:0]                state, state_nx;
    logic [2:0]                mode_q;
    logic [DATA_WIDTH-1:0]     fixed_q;
    logic [THROTTLE_WIDTH-1:0] throttle, throttle_nx;
    logic [DATA_WIDTH-1:0]     lfsr, lfsr_nx, lfsr_seed;
    logic [DATA_WIDTH-1:0]     expected;
    logic [31:0]               lane_s;
    logic                      accept;
    logic                      compare_en;
    logic                      mis_q;
    logic [31:0]               idx_q;

    assign accept     = pipe_in_write && (state == S_RUN);
    assign compare_en = (mode_q < 3'd5);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = S_LOAD;
            S_LOAD:  state_nx = S_RUN;
            S_RUN:   state_nx = S_RUN;
            default: state_nx = S_IDLE;
        endcase
    end

    assign throttle_nx = throttle_set ? throttle_val
                                      : ((throttle >> 1) | (throttle << (THROTTLE_WIDTH - 1)));

    // Each 32-bit lane runs its own LFSR; lane k starts with bit k set.
    always_comb begin
        lfsr_seed = '0;
        lfsr_nx   = '0;
        lane_s    = '0;
        for (int k = 0; k < LANES; k++) begin
            lfsr_seed[32*k +: 32] = 32'h1 << k;
            lane_s                = lfsr[32*k +: 32];
            lfsr_nx[32*k +: 32]   = {lane_s[30:0], lane_s[31] ^ lane_s[21] ^ lane_s[1] ^ lane_s[0]};
        end
    end

    always_comb begin
        expected = '0;
        case (mode_q)
            3'd0: expected[31:0] = word_count;
            3'd1: expected = fixed_q;
            3'd2: expected = lfsr;
            3'd3: expected[word_count[WB-1:0]] = 1'b1;
            3'd4: expected = word_count[0] ? ~fixed_q : fixed_q;
            default: expected = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= S_IDLE;
            mode_q          <= 3'd0;
            fixed_q         <= '0;
            throttle        <= '1;
            pipe_in_ready   <= 1'b0;
            lfsr            <= lfsr_seed;
            word_count      <= '0;
            mis_q           <= 1'b0;
            idx_q           <= '0;
            error_count     <= '0;
            first_err_valid <= 1'b0;
            first_err_index <= '0;
        end else begin
            state    <= state_nx;
            throttle <= throttle_nx;
            // Ready is registered from next-state values so it lines up with the throttle bit.
            pipe_in_ready <= (state_nx == S_RUN) && throttle_nx[0];

            if (state == S_LOAD) begin
                mode_q  <= pattern;
                fixed_q <= fixed_pattern;
            end

            mis_q <= accept && compare_en && (pipe_in_data != expected);
            if (accept) begin
                idx_q      <= word_count;
                word_count <= word_count + 32'd1;
                lfsr       <= lfsr_nx;
            end

            if (mis_q) begin
                if (error_count != '1)
                    error_count <= error_count + ERR_WIDTH'(1);
                if (!first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_index <= idx_q;
                end
            end
        end
    end

endmodule

// File: doc/pipe_in_verify.md
Name: pipe_in_verify

Overview:
Parametrised successor to the PipeIn checker. It sinks words from a BTPipeIn endpoint and compares each one against a locally generated expected sequence. It supports data widths of 32/64/128 bits and five pattern modes, with throttled ready, saturating error count, and first-error capture. It sits between okBTPipeIn and the status okWireOuts of the pipe test top.

Parameters:
DATA_WIDTH, 32, pipe word width; must be 32, 64 or 128 (lanes L = DATA_WIDTH/32)
ERR_WIDTH, 32, width of saturating error counter
THROTTLE_WIDTH, 32, width of ready-throttle rotate register

Ports:
clk  input  1  okClk domain clock
reset  input  1  asynchronous active-high reset
pipe_in_write  input  1  endpoint write strobe; data valid this cycle
pipe_in_data  input  DATA_WIDTH  endpoint write data
pipe_in_ready  output  1  block-level ready to endpoint
throttle_set  input  1  load throttle register from throttle_val
throttle_val  input  THROTTLE_WIDTH  throttle load value
pattern  input  3  pattern mode select
fixed_pattern  input  DATA_WIDTH  constant for fixed/alternating modes
error_count  output  ERR_WIDTH  saturating mismatch count
word_count  output  32  words received since reset, wraps
first_err_valid  output  1  sticky: at least one mismatch seen
first_err_index  output  32  word_count value of first mismatching word

Behaviour:
- Reset (async assert, sync release): state=IDLE; throttle=all ones; error_count=0; word_count=0; first_err_valid=0; first_err_index=0; pipe_in_ready=0; generator at seed; mismatch pipeline cleared.
- FSM IDLE -> LOAD -> RUN.
  - IDLE: one cycle after reset release.
  - LOAD: latch pattern -> mode_q and fixed_pattern -> fixed_q. Ready=0.
  - RUN: stays until reset. Later changes to pattern/fixed_pattern are ignored until the next reset.
- pipe_in_ready is registered: 1 only in RUN and when throttle[0]=1.
  - Each clock the throttle rotates right by one, bit0 -> MSB.
  - throttle_set=1 loads throttle_val instead of rotating, in any state. If it occurs during reset it is ignored.
- Write acceptance: writes in RUN are checked regardless of pipe_in_ready (ready is block-level advisory). Writes in IDLE/LOAD are dropped and not counted.
- Expected word for index n (n = word_count at the write):
  - mode 0 count: n zero-extended to DATA_WIDTH.
  - mode 1 fixed: fixed_q.
  - mode 2 LFSR: lane k (bits 32k+31:32k) seeded 32'h1 << k. Each write advances every lane: next = {s[30:0], s[31]^s[21]^s[1]^s[0]}. Word 0 = seeds.
  - mode 3 walking one: 1 << (n mod DATA_WIDTH).
  - mode 4 alternating: fixed_q when n even, ~fixed_q when n odd.
  - modes 5-7: compare disabled. Words are counted but error_count never increments.
- Pipeline:
  - Edge of write cycle: register mismatch=(data!=expected), register index n, increment word_count (wraps at 2^32), advance generator.
  - Next edge: if mismatch, error_count += 1, saturating at all ones (no wrap). If also first_err_valid=0, set first_err_valid=1 and first_err_index=registered n.
  - Total latency from write to error_count update: 2 edges. Back-to-back writes are sustained every cycle.
- Error accounting is per-word mismatch (one count per bad word, regardless of bit count).
- Reset mid-stream: any in-flight mismatch is discarded. All counters return to reset values and the generator reseeds; the next stream restarts at n=0 after IDLE/LOAD.

Test Plan:
- Count mode (DW=32, pattern=0), throttle default, write 0,1,2,3 in RUN -> word_count=4, error_count=0, first_err_valid=0.
- Count mode, write 0,1,5,3 -> 2 edges after the third write: error_count=1, first_err_valid=1, first_err_index=2. Fourth word adds no error.
- throttle_set with throttle_val=32'hAAAAAAAA in RUN -> ready alternates 0,1,0,1 beginning the cycle after load. Write while ready=0 is still checked and counted.
- LFSR, DW=64: first two words = 64'h00000002_00000001 and the next state per lane -> error_count=0. Flipping bit 40 of word 1 -> error_count=1, first_err_index=1.
- ERR_WIDTH=4, fixed mode, fixed_pattern=32'hDEADBEEF, 20 words of 0 -> error_count=4'hF (saturated), first_err_index=0.
- 10 counting words, assert reset for 1 cycle, change pattern to 3, then write 1,2,4 -> word_count=3, error_count=0. Writes during IDLE/LOAD are ignored.
